cordic_vec_scheduler: RTL and testbench

CORDIC_VEC_SCHEDULER -- requirements
Module: cordic_vec_scheduler

---
 rtl/cordic_pkg.sv | 15 +
 rtl/cordic_vec_scheduler_rr_arbiter.sv | 41 ++++
 rtl/cordic_vec_scheduler.sv | 129 ++++++++++++
 tb/tb_cordic_vec_scheduler.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and the response tag carried alongside each operand
// through the vectoring core's fixed-latency pipeline.
package cordic_pkg;

    localparam int CORDIC_W    = 32;
    localparam int CORDIC_FRAC = 20;
    localparam int CORDIC_LAT  = 17;
    localparam int TAG_ID_W    = 3;  // wide enough for up to 8 requesters

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/cordic_vec_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible index at or after ptr,
// then moves ptr just past the winner. ptr holds when nothing is granted.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] eligible,
    output logic [NREQ-1:0] grant,
    output logic            grant_any,
    output logic [IDW-1:0]  grant_id,
    output logic [IDW-1:0]  ptr
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!grant_any && eligible[idx]) begin
                grant[idx] = 1'b1;
                grant_any  = 1'b1;
                grant_id   = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/cordic_vec_scheduler.sv
// Shares one pipelined CORDIC vectoring core among NREQ requesters and routes
// each result back by id. Optional per-requester grant counters: CORDIC_SCHED_STATS_EN.
module cordic_vec_scheduler
    import cordic_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = CORDIC_W,
    parameter int LAT     = CORDIC_LAT,
    parameter int MAX_OUT = 4,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic [W-1:0]    core_x0,
    output logic [W-1:0]    core_y0,
    input  logic [W-1:0]    core_xf,
    input  logic [W-1:0]    core_angle,
    output logic            rsp_valid,
    output logic [IDW-1:0]  rsp_id,
    output logic [W-1:0]    rsp_mag,
    output logic [W-1:0]    rsp_angle,
    output logic            busy
`ifdef CORDIC_SCHED_STATS_EN
    ,
    output logic [NREQ*16-1:0] grant_cnt
`endif
);

    localparam int CW = $clog2(MAX_OUT + 1);

    // Handshake: requester i transfers on a cycle where req_valid[i] && req_ready[i];
    // req_ready is combinational and may be offered only while valid is high.
    // The response side has no backpressure: every rsp_valid cycle is consumed.
    logic [CW-1:0]   outstanding [NREQ];
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] rsp_hit;
    logic            grant_any;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  ptr;
    tag_t            tags [LAT];
    tag_t            fin;

    assign fin = tags[LAT-1];

    // rst gates eligibility so the outputs go quiet the instant reset asserts
    always_comb begin
        eligible = '0;
        rsp_hit  = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && (outstanding[i] < CW'(MAX_OUT)) && !flush && !rst;
            rsp_hit[i]  = fin.valid && (fin.id == TAG_ID_W'(i));
        end
    end

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .eligible (eligible),
        .grant    (grant),
        .grant_any(grant_any),
        .grant_id (grant_id),
        .ptr      (ptr)
    );

    assign req_ready = grant;

    always_comb begin
        core_x0 = '0;
        core_y0 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                core_x0 = req_x[i*W +: W];
                core_y0 = req_y[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) tags[s] <= '0;
        end else if (flush) begin
            for (int s = 0; s < LAT; s++) tags[s] <= '0;
        end else begin
            tags[0] <= '{valid: grant_any, id: TAG_ID_W'(grant_id)};
            for (int s = 1; s < LAT; s++) tags[s] <= tags[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) outstanding[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (flush)                       outstanding[i] <= '0;
                else if (grant[i] && !rsp_hit[i]) outstanding[i] <= outstanding[i] + 1'b1;
                else if (!grant[i] && rsp_hit[i]) outstanding[i] <= outstanding[i] - 1'b1;
            end
        end
    end

    always_comb begin
        rsp_valid = fin.valid;
        rsp_id    = fin.valid ? fin.id[IDW-1:0] : '0;
        rsp_mag   = fin.valid ? core_xf : '0;
        rsp_angle = fin.valid ? core_angle : '0;
        busy      = 1'b0;
        for (int s = 0; s < LAT; s++) busy = busy | tags[s].valid;
    end

`ifdef CORDIC_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cordic_vec_scheduler.sv
// Bench for cordic_vec_scheduler with a behavioural fixed-latency vectoring core
// (angle in degrees, 20 fraction bits) and an expected-response queue.
module tb_cordic_vec_scheduler;
    import cordic_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int LAT  = 17;
`ifdef CORDIC_SCHED_STATS_EN
    localparam int MAX_OUT = 5;
`else
    localparam int MAX_OUT = 4;
`endif
    localparam int IDW = 2;
    localparam int EW  = 32 + IDW + 2 * W;

    logic              clk, rst, flush;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*W-1:0] req_x, req_y;
    logic [W-1:0]      core_x0, core_y0, core_xf, core_angle;
    logic              rsp_valid, busy;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_mag, rsp_angle;
`ifdef CORDIC_SCHED_STATS_EN
    logic [NREQ*16-1:0] grant_cnt;
`endif

    logic [W-1:0] drv_x [NREQ];
    logic [W-1:0] drv_y [NREQ];
    logic [W-1:0] px [LAT];
    logic [W-1:0] py [LAT];
    logic [EW-1:0] exp_q [$];
    logic [31:0]    e_cyc;
    logic [IDW-1:0] e_id;
    logic [W-1:0]   e_mag, e_ang;
    int checks, errors, cyc;

    cordic_vec_scheduler #(.NREQ(NREQ), .W(W), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .core_x0   (core_x0),
        .core_y0   (core_y0),
        .core_xf   (core_xf),
        .core_angle(core_angle),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_mag   (rsp_mag),
        .rsp_angle (rsp_angle),
        .busy      (busy)
`ifdef CORDIC_SCHED_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*W +: W] = drv_x[i];
            req_y[i*W +: W] = drv_y[i];
        end
    end

    function automatic logic [W-1:0] mag_of(input logic [W-1:0] x, input logic [W-1:0] y);
        real xr, yr;
        xr = $itor($signed(x));
        yr = $itor($signed(y));
        return W'($rtoi($sqrt(xr * xr + yr * yr)));
    endfunction

    function automatic logic [W-1:0] ang_of(input logic [W-1:0] x, input logic [W-1:0] y);
        real xr, yr;
        xr = $itor($signed(x));
        yr = $itor($signed(y));
        return W'($rtoi($atan2(yr, xr) * 180.0 / 3.14159265358979 * 1048576.0));
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        v = W'($urandom_range(0, 32'h00FF_FFFF));
        return v - 32'h0080_0000;
    endfunction

    // Behavioural core: LAT-stage operand pipe, result computed at the output.
    always @(posedge clk) begin
        px[0] <= core_x0;
        py[0] <= core_y0;
        for (int s = 1; s < LAT; s++) begin
            px[s] <= px[s-1];
            py[s] <= py[s-1];
        end
    end
    assign core_xf    = mag_of(px[LAT-1], py[LAT-1]);
    assign core_angle = ang_of(px[LAT-1], py[LAT-1]);

    // Scoreboard: push on every observed transfer, pop on every response.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(req_ready) > 1) begin
                errors++;
                $display("FAIL onehot: req_ready=%b, required at most one bit", req_ready);
            end
            if (req_ready == '0) begin
                checks++;
                if (core_x0 !== '0 || core_y0 !== '0) begin
                    errors++;
                    $display("FAIL idle_operands: core_x0=%h core_y0=%h, required 0", core_x0, core_y0);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    checks++;
                    if (!req_valid[i] || core_x0 !== drv_x[i] || core_y0 !== drv_y[i]) begin
                        errors++;
                        $display("FAIL issue_operands: req %0d valid=%b x0=%h y0=%h, required x0=%h y0=%h",
                                 i, req_valid[i], core_x0, core_y0, drv_x[i], drv_y[i]);
                    end
                    exp_q.push_back({32'(cyc + LAT), IDW'(i), mag_of(drv_x[i], drv_y[i]), ang_of(drv_x[i], drv_y[i])});
                end
            end
            checks++;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: cycle %0d id=%0d, required no response", cyc, rsp_id);
                end else begin
                    {e_cyc, e_id, e_mag, e_ang} = exp_q.pop_front();
                    if (32'(cyc) !== e_cyc || rsp_id !== e_id || rsp_mag !== e_mag || rsp_angle !== e_ang) begin
                        errors++;
                        $display("FAIL rsp: cycle %0d id=%0d mag=%h ang=%h, required cycle %0d id=%0d mag=%h ang=%h",
                                 cyc, rsp_id, rsp_mag, rsp_angle, e_cyc, e_id, e_mag, e_ang);
                    end
                end
            end else if (rsp_id !== '0 || rsp_mag !== '0 || rsp_angle !== '0) begin
                errors++;
                $display("FAIL idle_rsp: id=%0d mag=%h ang=%h, required all 0", rsp_id, rsp_mag, rsp_angle);
            end
        end
        cyc++;
    end

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        req_valid = '0;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < LAT + 20 && !ok; k++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: busy_cleared=%0d pending=%0d, required 1 and 0", ok, exp_q.size());
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0 || core_x0 !== '0 || core_y0 !== '0 || rsp_id !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rsp_valid=%b busy=%b x0=%h y0=%h id=%0d, required all 0",
                     req_ready, rsp_valid, busy, core_x0, core_y0, rsp_id);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: ready=%b busy=%b, required 0 and 0", req_ready, busy);
        end
    endtask

    task automatic test_single();
        bit got;
        int dm, da;
        @(posedge clk);
        #1;
        drv_x[2] = 32'h0030_0000;
        drv_y[2] = 32'h0040_0000;
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b, required 0100", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        got = 1'b0;
        for (int k = 1; k <= LAT + 4 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                dm = int'($signed(rsp_mag)) - 32'h0050_0000;
                da = int'($signed(rsp_angle)) - 32'h0352_14E4;
                checks++;
                if (k != LAT || rsp_id !== 2'd2 || dm > 256 || dm < -256 || da > 256 || da < -256) begin
                    errors++;
                    $display("FAIL single_rsp: latency=%0d id=%0d mag=%h ang=%h, required %0d 2 ~00500000 ~035214e4",
                             k, rsp_id, rsp_mag, rsp_angle, LAT);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL single_timeout: no rsp_valid within %0d cycles, required one", LAT + 4);
        end
        wait_idle();
    endtask

    task automatic test_round_robin();
        do_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            drv_x[i] = rnd_op();
            drv_y[i] = rnd_op();
        end
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== NREQ'(1 << (k % NREQ))) begin
                errors++;
                $display("FAIL rr_order: cycle %0d req_ready=%b, required %b", k, req_ready, NREQ'(1 << (k % NREQ)));
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_credit();
        bit exp_rdy;
        do_reset();
        @(posedge clk);
        #1;
        drv_x[1] = rnd_op();
        drv_y[1] = rnd_op();
        req_valid = 4'b0010;
        for (int k = 0; k <= LAT + MAX_OUT; k++) begin
            @(negedge clk);
            exp_rdy = (k < MAX_OUT) || (k >= LAT + 1 && k <= LAT + MAX_OUT);
            checks++;
            if (req_ready[1] !== exp_rdy) begin
                errors++;
                $display("FAIL credit: cycle %0d req_ready[1]=%b, required %b", k, req_ready[1], exp_rdy);
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_flush();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            drv_x[i] = rnd_op();
            drv_y[i] = rnd_op();
        end
        req_valid = 4'b0111;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        req_valid = '1;
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || core_x0 !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle: ready=%b x0=%h busy=%b, required 0 0 1", req_ready, core_x0, busy);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || $countones(req_ready) != 1) begin
            errors++;
            $display("FAIL after_flush: busy=%b ready=%b, required 0 and one grant", busy, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            drv_x[i] = rnd_op();
            drv_y[i] = rnd_op();
        end
        req_valid = '1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0 || core_x0 !== '0 || core_y0 !== '0) begin
            errors++;
            $display("FAIL async_reset: ready=%b rsp_valid=%b busy=%b x0=%h y0=%h, required all 0",
                     req_ready, rsp_valid, busy, core_x0, core_y0);
        end
        exp_q.delete();
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        req_valid = '1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL ptr_after_reset: req_ready=%b, required 0001", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                drv_x[i] = rnd_op();
                drv_y[i] = rnd_op();
            end
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();
    endtask

`ifdef CORDIC_SCHED_STATS_EN
    task automatic test_stats();
        do_reset();
        @(posedge clk);
        #1;
        req_valid = '1;
        repeat (100) @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            checks++;
            if (grant_cnt[i*16 +: 16] !== 16'd25) begin
                errors++;
                $display("FAIL stats: grant_cnt[%0d]=%0d, required 25", i, grant_cnt[i*16 +: 16]);
            end
        end
        wait_idle();
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        flush  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            drv_x[i] = rnd_op();
            drv_y[i] = rnd_op();
        end
        req_valid = '1;
        test_reset();
        test_single();
        test_round_robin();
        test_credit();
        test_flush();
        test_async_reset();
        test_back_to_back();
`ifdef CORDIC_SCHED_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
